// File: rtl/mod6_run_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mod6_run_controller                                        |
// | Description : Run sequencer for a modulo-6 counter. Clears the counter,  |
// |               pulses its enable every div+1 clocks, counts full 0..5     |
// |               laps and pulses done once the latched lap target is hit.  |
// |               Optional feature macro: MOD6_RUN_AUTORELOAD_EN (adds the   |
// |               reload input; DONE may restart a run without a new start). |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mod6_run_controller #(
  parameter int DIV_W  = 8,
  parameter int WRAP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              hold,
  input  logic              abort,
`ifdef MOD6_RUN_AUTORELOAD_EN
  input  logic              reload,
`endif
  input  logic [DIV_W-1:0]  div,
  input  logic [WRAP_W-1:0] laps,
  input  logic [2:0]        cnt_q,
  output logic              cnt_en,
  output logic              cnt_clr,
  output logic              busy,
  output logic              paused,
  output logic              done,
  output logic [WRAP_W-1:0] laps_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [WRAP_W-1:0] LAPS_MAX = '1;

  state_t            state, state_nx;
  logic [DIV_W-1:0]  divider, divider_nx, div_l;
  logic [WRAP_W-1:0] laps_l, laps_done_nx, lap_inc;
  logic              tick, accept;

  // The divider reaching the latched rate marks an enable slot.
  assign tick    = (divider == div_l);
  // Lap count saturates at all-ones instead of wrapping.
  assign lap_inc = (laps_done == LAPS_MAX) ? laps_done : laps_done + 1'b1;

  // Next-state and output decode; abort outranks hold, hold outranks the tick.
  always_comb begin
    state_nx     = state;
    divider_nx   = divider;
    laps_done_nx = laps_done;
    accept       = 1'b0;
    cnt_en       = 1'b0;
    cnt_clr      = 1'b0;
    busy         = 1'b0;
    paused       = 1'b0;
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          accept   = 1'b1;
          state_nx = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_clr = 1'b1;
        busy    = 1'b1;
        if (abort) begin
          state_nx = S_IDLE;
        end else begin
          divider_nx   = '0;
          laps_done_nx = '0;
          state_nx     = (laps_l == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (abort) begin
          cnt_clr  = 1'b1;
          state_nx = S_IDLE;
        end else if (hold) begin
          // Divider is frozen here so the resume continues the same slot.
          state_nx = S_PAUSE;
        end else begin
          cnt_en     = tick;
          divider_nx = tick ? '0 : divider + 1'b1;
          // Out-of-range counter values (6, 7) never count as a lap.
          if (tick && (cnt_q == 3'd5)) begin
            laps_done_nx = lap_inc;
            if (lap_inc == laps_l) begin
              state_nx = S_DONE;
            end
          end
        end
      end
      S_PAUSE: begin
        busy   = 1'b1;
        paused = 1'b1;
        if (abort) begin
          cnt_clr  = 1'b1;
          state_nx = S_IDLE;
        end else if (!hold) begin
          state_nx = S_RUN;
        end
      end
      S_DONE: begin
        done = 1'b1;
`ifdef MOD6_RUN_AUTORELOAD_EN
        state_nx = reload ? S_CLEAR : S_IDLE;
`else
        state_nx = S_IDLE;
`endif
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State, divider, lap count and the run settings captured on start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      divider   <= '0;
      laps_done <= '0;
      div_l     <= '0;
      laps_l    <= '0;
    end else begin
      state     <= state_nx;
      divider   <= divider_nx;
      laps_done <= laps_done_nx;
      if (accept) begin
        div_l  <= div;
        laps_l <= laps;
      end
    end
  end

endmodule
`default_nettype wire
